// File: rtl/riscv_cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : riscv_cache_pkg                                                  |
// | Brief   : Shared types, default widths and address-split helpers for the   |
// |           direct-mapped write-through data cache.                          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package riscv_cache_pkg;

   localparam int c_ADDR_W  = 10;
   localparam int c_DATA_W  = 32;
   localparam int c_INDEX_W = 5;
   localparam int c_TAG_W   = c_ADDR_W - c_INDEX_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_MISS = 2'd1,
      ST_WR_THRU = 2'd2
   } state_t;

   function automatic logic [c_INDEX_W-1:0] addr_index(input logic [c_ADDR_W-1:0] addr);
      return addr[c_INDEX_W-1:0];
   endfunction

   function automatic logic [c_TAG_W-1:0] addr_tag(input logic [c_ADDR_W-1:0] addr);
      return addr[c_ADDR_W-1:c_INDEX_W];
   endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_line_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dcache_line_array                                                |
// | Brief   : Valid/tag/data storage for one-word lines; sync fill/update,     |
// |           async lookup with hit detection.                                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module dcache_line_array
   import riscv_cache_pkg::*;
#(
   parameter int INDEX_W = c_INDEX_W,
   parameter int TAG_W   = c_TAG_W,
   parameter int DATA_W  = c_DATA_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] index,
   input  logic [TAG_W-1:0]   tag,
   input  logic               fill_en,
   input  logic               upd_en,
   input  logic [DATA_W-1:0]  wr_data,
   output logic               hit,
   output logic [DATA_W-1:0]  rd_data
);

   localparam int c_LINES = 1 << INDEX_W;

   logic [c_LINES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag  [c_LINES];
   logic [DATA_W-1:0]  r_data [c_LINES];

   always_ff @(posedge clk) begin
      if (rst)
         r_valid <= '0;
      else if (fill_en)
         r_valid[index] <= 1'b1;
   end

   // Tag/data need no reset: nothing reads them while the valid bit is clear.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         r_tag[index]  <= tag;
         r_data[index] <= wr_data;
      end else if (upd_en) begin
         r_data[index] <= wr_data;
      end
   end

   assign hit     = r_valid[index] && (r_tag[index] == tag);
   assign rd_data = r_data[index];

endmodule
`default_nettype wire

// File: rtl/dcache_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dcache_mem_ctrl                                                  |
// | Brief   : Direct-mapped, write-through, no-write-allocate data cache       |
// |           controller driving the WE/RE/ready memory handshake.             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module dcache_mem_ctrl
   import riscv_cache_pkg::*;
#(
   parameter int ADDR_W  = c_ADDR_W,
   parameter int DATA_W  = c_DATA_W,
   parameter int INDEX_W = c_INDEX_W,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_re,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wd,
   output logic [DATA_W-1:0] cpu_rd,
   output logic              cpu_stall,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd,
   input  logic              mem_ready,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int c_TAG_W = ADDR_W - INDEX_W;

   state_t              r_state;
   state_t              w_next;
   logic [INDEX_W-1:0]  w_index;
   logic [c_TAG_W-1:0]  w_tag;
   logic                w_hit;
   logic [DATA_W-1:0]   w_line_data;
   logic                w_fill;
   logic                w_upd;
   logic [DATA_W-1:0]   w_line_wd;
   logic                w_hit_inc;
   logic                w_miss_inc;
   logic [CNT_W-1:0]    r_hit_cnt;
   logic [CNT_W-1:0]    r_miss_cnt;

   assign w_index = cpu_addr[INDEX_W-1:0];
   assign w_tag   = cpu_addr[ADDR_W-1:INDEX_W];

   dcache_line_array #(
      .INDEX_W (INDEX_W),
      .TAG_W   (c_TAG_W),
      .DATA_W  (DATA_W)
   ) u_lines (
      .clk     (clk),
      .rst     (rst),
      .index   (w_index),
      .tag     (w_tag),
      .fill_en (w_fill),
      .upd_en  (w_upd),
      .wr_data (w_line_wd),
      .hit     (w_hit),
      .rd_data (w_line_data)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // Requests drop combinationally in the ready cycle so memory never sees a 5th beat.
   always_comb begin
      w_next     = r_state;
      cpu_stall  = 1'b0;
      cpu_rd     = '0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      mem_addr   = cpu_addr;
      mem_wd     = cpu_wd;
      w_fill     = 1'b0;
      w_upd      = 1'b0;
      w_line_wd  = cpu_wd;
      w_hit_inc  = 1'b0;
      w_miss_inc = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cpu_we) begin
               cpu_stall = 1'b1;
               w_next    = ST_WR_THRU;
            end else if (cpu_re) begin
               if (w_hit) begin
                  cpu_rd    = w_line_data;
                  w_hit_inc = 1'b1;
               end else begin
                  cpu_stall = 1'b1;
                  w_next    = ST_RD_MISS;
               end
            end
         end
         ST_RD_MISS: begin
            mem_re = ~mem_ready;
            if (mem_ready) begin
               cpu_rd     = mem_rd;
               w_fill     = 1'b1;
               w_line_wd  = mem_rd;
               w_miss_inc = 1'b1;
               w_next     = ST_IDLE;
            end else begin
               cpu_stall = 1'b1;
            end
         end
         ST_WR_THRU: begin
            mem_we = ~mem_ready;
            if (mem_ready) begin
               w_upd  = w_hit;
               w_next = ST_IDLE;
            end else begin
               cpu_stall = 1'b1;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_hit_inc && (r_hit_cnt != '1))
            r_hit_cnt <= r_hit_cnt + 1'b1;
         if (w_miss_inc && (r_miss_cnt != '1))
            r_miss_cnt <= r_miss_cnt + 1'b1;
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;

endmodule
`default_nettype wire
